// File: rtl/lcd_alu_display_pkg.sv
// rtl/lcd_alu_display_pkg.sv - LCD command/char codes, FSM states and helpers for lcd_alu_display
package lcd_alu_display_pkg;

    // HD44780-style command bytes used by the init sequence and line addressing
    localparam logic [7:0] LCD_FUNC_SET = 8'h28;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;

    // Character codes for the operator, equals sign and padding
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam int PWR_STEPS  = 16;
    localparam int INIT_LEN   = 8;
    localparam int LINE_CHARS = 16;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHARS
    } state_t;

    // One hex digit to its ASCII code, upper-case letters
    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'd0, v}) : (8'h37 + {4'd0, v});
    endfunction

    // Init item: {is_nibble, byte}; the first four are bare nibbles that
    // force the controller into 4-bit mode, the rest are full commands
    function automatic logic [8:0] init_item(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return {1'b1, 8'h03};
            3'd3:             return {1'b1, 8'h02};
            3'd4:             return {1'b0, LCD_FUNC_SET};
            3'd5:             return {1'b0, LCD_DISP_ON};
            3'd6:             return {1'b0, LCD_CLEAR};
            default:          return {1'b0, LCD_ENTRY};
        endcase
    endfunction

endpackage

// File: rtl/lcd_alu_display_nibble_tx.sv
// rtl/lcd_alu_display_nibble_tx.sv - step timer, byte-to-nibble splitter and LCD enable strobe
module lcd_alu_display_nibble_tx #(
    parameter int STEP_BITS = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    input  logic       i_rs,
    input  logic       i_is_nibble,
    output logic       o_ready,
    output logic       o_done,
    output logic       o_e,
    output logic       o_rs,
    output logic [3:0] o_nib
);

    logic [STEP_BITS-1:0] r_cnt;
    logic                 r_active;
    logic                 r_pend_low;
    logic [3:0]           r_low;
    logic                 r_e;
    logic                 r_rs;
    logic [3:0]           r_nib;

    logic [STEP_BITS-1:0] w_cnt_nxt;
    logic                 w_tick;
    logic                 w_accept;
    logic                 w_active_nxt;

    // Steps change only on counter wrap; a new byte is taken only when no low nibble is pending
    assign w_cnt_nxt    = r_cnt + 1'b1;
    assign w_tick       = &r_cnt;
    assign o_ready      = w_tick && !r_pend_low;
    assign w_accept     = i_valid && o_ready;
    assign o_done       = w_tick && r_active && !r_pend_low;
    assign w_active_nxt = w_tick ? (r_pend_low || w_accept) : r_active;

    assign o_e   = r_e;
    assign o_rs  = r_rs;
    assign o_nib = r_nib;

    // Free-running step timer, nibble sequencing and e window (middle half of a step)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_active   <= 1'b0;
            r_pend_low <= 1'b0;
            r_low      <= 4'd0;
            r_e        <= 1'b0;
            r_rs       <= 1'b0;
            r_nib      <= 4'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_e   <= w_active_nxt && (w_cnt_nxt[STEP_BITS-1] ^ w_cnt_nxt[STEP_BITS-2]);
            if (w_tick) begin
                r_active <= w_active_nxt;
                if (r_pend_low) begin
                    r_nib      <= r_low;
                    r_pend_low <= 1'b0;
                end else if (w_accept) begin
                    r_nib      <= i_is_nibble ? i_byte[3:0] : i_byte[7:4];
                    r_low      <= i_byte[3:0];
                    r_rs       <= i_rs;
                    r_pend_low <= !i_is_nibble;
                end else begin
                    r_nib <= 4'd0;
                    r_rs  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_alu_display.sv
// rtl/lcd_alu_display.sv - switch-loaded add/sub ALU shown as "AA+BB=RRR" on a 4-bit character LCD
module lcd_alu_display
    import lcd_alu_display_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STEP_BITS = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [2:0]       btn,
    output logic             carry,
    output logic             ovf,
    output logic             sf_e,
    output logic             e,
    output logic             rs,
    output logic             rw,
    output logic             d,
    output logic             c,
    output logic             b,
    output logic             a
);

    localparam int ND = (WIDTH + 3) / 4;
    localparam int NR = (WIDTH + 4) / 4;

    logic [2:0]       r_btn;
    logic [2:0]       r_btn_prev;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_carry;
    logic             r_ovf;
    logic             r_sf_e;
    logic             r_dirty;
    logic [WIDTH-1:0] r_snap_a;
    logic [WIDTH-1:0] r_snap_b;
    logic             r_snap_sub;
    logic [WIDTH:0]   r_snap_res;
    state_t           r_state;
    logic [3:0]       r_idx;
    logic [3:0]       r_wait;
    logic             r_tx_busy;

    logic [2:0]       w_edge;
    logic [WIDTH:0]   w_res;
    logic             w_ovf;
    logic             w_snap;
    logic [4*ND-1:0]  w_a_pad;
    logic [4*ND-1:0]  w_b_pad;
    logic [4*NR-1:0]  w_r_pad;
    int               w_pos;
    logic [7:0]       w_char;
    logic             w_valid;
    logic [7:0]       w_byte;
    logic             w_rs;
    logic             w_is_nib;
    logic             w_tx_ready;
    logic             w_tx_done;
    logic             w_tx_e;
    logic             w_tx_rs;
    logic [3:0]       w_tx_nib;
    logic             w_accept;

    assign w_edge   = r_btn & ~r_btn_prev;
    assign w_snap   = (r_state == ST_IDLE) && r_dirty && !r_tx_busy;
    assign w_accept = w_valid && w_tx_ready;
    assign w_a_pad  = (4*ND)'(r_snap_a);
    assign w_b_pad  = (4*ND)'(r_snap_b);
    assign w_r_pad  = (4*NR)'(r_snap_res);
    assign w_pos    = int'(r_idx);

    // Arithmetic on the live operands; sub yields the borrow in the top bit
    always_comb begin
        w_res = r_sub ? ({1'b0, r_a} - {1'b0, r_b}) : ({1'b0, r_a} + {1'b0, r_b});
        if (r_sub)
            w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
        else
            w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
    end

    // Character for the current column, built only from the frame snapshot
    always_comb begin
        w_char = CH_SPACE;
        if (w_pos < ND)
            w_char = hex_ascii(4'(w_a_pad >> (4 * (ND - 1 - w_pos))));
        else if (w_pos == ND)
            w_char = r_snap_sub ? CH_MINUS : CH_PLUS;
        else if (w_pos < 2*ND + 1)
            w_char = hex_ascii(4'(w_b_pad >> (4 * (2*ND - w_pos))));
        else if (w_pos == 2*ND + 1)
            w_char = CH_EQ;
        else if (w_pos < 2*ND + 2 + NR)
            w_char = hex_ascii(4'(w_r_pad >> (4 * (2*ND + 1 + NR - w_pos))));
    end

    // Request offered to the nibble transmitter in each state
    always_comb begin
        w_valid  = 1'b0;
        w_byte   = 8'h00;
        w_rs     = 1'b0;
        w_is_nib = 1'b0;
        case (r_state)
            ST_PWR_WAIT: begin
                w_valid            = (r_wait == 4'(PWR_STEPS - 1));
                {w_is_nib, w_byte} = init_item(3'd0);
            end
            ST_INIT: begin
                w_valid            = 1'b1;
                {w_is_nib, w_byte} = init_item(r_idx[2:0]);
            end
            ST_ADDR: begin
                w_valid = 1'b1;
                w_byte  = LCD_LINE1;
            end
            ST_CHARS: begin
                w_valid = 1'b1;
                w_rs    = 1'b1;
                w_byte  = w_char;
            end
            default: ;
        endcase
    end

    // Buttons, operand/mode registers, flags and the init/write sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn      <= 3'd0;
            r_btn_prev <= 3'd0;
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_sf_e     <= 1'b1;
            r_dirty    <= 1'b1;
            r_snap_a   <= '0;
            r_snap_b   <= '0;
            r_snap_sub <= 1'b0;
            r_snap_res <= '0;
            r_state    <= ST_PWR_WAIT;
            r_idx      <= 4'd0;
            r_wait     <= 4'd0;
            r_tx_busy  <= 1'b0;
        end else begin
            r_btn      <= btn;
            r_btn_prev <= r_btn;
            r_sf_e     <= 1'b1;
            r_carry    <= w_res[WIDTH];
            r_ovf      <= w_ovf;
            if (w_edge[0]) r_a <= sw;
            if (w_edge[1]) r_b <= sw;
            if (w_edge[2]) r_sub <= ~r_sub;

            // An edge landing on the snapshot cycle must still schedule another frame
            if (|w_edge)
                r_dirty <= 1'b1;
            else if (w_snap)
                r_dirty <= 1'b0;

            if (w_accept)
                r_tx_busy <= 1'b1;
            else if (w_tx_done)
                r_tx_busy <= 1'b0;

            case (r_state)
                ST_PWR_WAIT: begin
                    if (w_accept) begin
                        r_state <= ST_INIT;
                        r_idx   <= 4'd1;
                    end else if (w_tx_ready) begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                ST_INIT: begin
                    if (w_accept) begin
                        if (r_idx == 4'(INIT_LEN - 1)) begin
                            r_state <= ST_IDLE;
                            r_idx   <= 4'd0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (w_snap) begin
                        r_snap_a   <= r_a;
                        r_snap_b   <= r_b;
                        r_snap_sub <= r_sub;
                        r_snap_res <= w_res;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_accept) begin
                        r_state <= ST_CHARS;
                        r_idx   <= 4'd0;
                    end
                end
                ST_CHARS: begin
                    if (w_accept) begin
                        if (r_idx == 4'(LINE_CHARS - 1)) begin
                            r_state <= ST_IDLE;
                            r_idx   <= 4'd0;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: r_state <= ST_PWR_WAIT;
            endcase
        end
    end

    lcd_alu_display_nibble_tx #(
        .STEP_BITS (STEP_BITS)
    ) u_tx (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_valid),
        .i_byte      (w_byte),
        .i_rs        (w_rs),
        .i_is_nibble (w_is_nib),
        .o_ready     (w_tx_ready),
        .o_done      (w_tx_done),
        .o_e         (w_tx_e),
        .o_rs        (w_tx_rs),
        .o_nib       (w_tx_nib)
    );

    assign carry        = r_carry;
    assign ovf          = r_ovf;
    assign sf_e         = r_sf_e;
    assign e            = w_tx_e;
    assign rs           = w_tx_rs;
    assign rw           = 1'b0;
    assign {d, c, b, a} = w_tx_nib;

endmodule

// File: tb/tb_lcd_alu_display.sv
// tb/tb_lcd_alu_display.sv - directed self-checking bench for lcd_alu_display
module tb_lcd_alu_display;

    localparam int WIDTH     = 8;
    localparam int STEP_BITS = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] sw  = '0;
    logic [2:0]       btn = 3'd0;
    logic             carry, ovf, sf_e, e, rs, rw, d, c, b, a;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_e_cyc = -1;

    logic [4:0] mon_q[$];
    logic       prev_e = 1'b0;

    logic [7:0] fr_ch[16];
    bit         fr_ok;
    bit         fr_rs_ok;

    always #5 clk = ~clk;

    lcd_alu_display #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .btn   (btn),
        .carry (carry),
        .ovf   (ovf),
        .sf_e  (sf_e),
        .e     (e),
        .rs    (rs),
        .rw    (rw),
        .d     (d),
        .c     (c),
        .b     (b),
        .a     (a)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            prev_e = 1'b0;
        end else begin
            if (e && !prev_e) begin
                mon_q.push_back({rs, d, c, b, a});
                if (first_e_cyc < 0) first_e_cyc = cyc;
            end
            prev_e = e;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired n_tests=%0d n_fail=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic get_nib(output logic [4:0] v, output bit ok);
        int t = 0;
        v = '0;
        while (mon_q.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        ok = (mon_q.size() > 0);
        if (ok) v = mon_q.pop_front();
    endtask

    task automatic get_frame();
        logic [4:0] n1, n2, hi, lo;
        bit ok, found;
        found    = 1'b0;
        fr_rs_ok = 1'b1;
        for (int i = 0; i < 16; i++) fr_ch[i] = 8'h00;
        get_nib(n1, ok);
        for (int i = 0; i < 200 && ok && !found; i++) begin
            get_nib(n2, ok);
            if (ok && n1 == 5'h08 && n2 == 5'h00) found = 1'b1;
            else n1 = n2;
        end
        for (int i = 0; i < 16 && ok && found; i++) begin
            get_nib(hi, ok);
            if (ok) get_nib(lo, ok);
            fr_ch[i] = {hi[3:0], lo[3:0]};
            if (!hi[4] || !lo[4]) fr_rs_ok = 1'b0;
        end
        fr_ok = ok && found;
    endtask

    function automatic string pad16(input string s);
        string r = s;
        while (r.len() < 16) r = {r, " "};
        return r;
    endfunction

    function automatic int frame_diff(input string exp);
        if (!fr_ok) return -2;
        for (int i = 0; i < 16; i++)
            if (fr_ch[i] !== exp[i]) return i;
        return -1;
    endfunction

    function automatic string frame_str();
        string s = "";
        for (int i = 0; i < 16; i++) s = $sformatf("%s%c", s, fr_ch[i]);
        return s;
    endfunction

    task automatic press(input int idx, input logic [WIDTH-1:0] val);
        @(negedge clk);
        sw       = val;
        btn[idx] = 1'b1;
        repeat (3) @(negedge clk);
        btn[idx] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] exp_init[12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                     5'h00, 5'h0C, 5'h00, 5'h01, 5'h00, 5'h06};
        logic [4:0] got;
        bit ok;
        int bad = -1;
        int c0;
        string exp;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (sf_e !== 1'b1 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sf_e_e got sf_e=%b e=%b exp sf_e=1 e=0", sf_e, e);
        end
        n_tests++;
        if ({carry, ovf, rs, rw, d, c, b, a} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp 00000000", {carry, ovf, rs, rw, d, c, b, a});
        end
        mon_q.delete();
        first_e_cyc = -1;
        c0  = cyc;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            get_nib(got, ok);
            if ((!ok || got !== exp_init[i]) && bad < 0) bad = i;
        end
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL init_sequence nibble %0d got %h exp %h", bad, got, exp_init[bad]);
        end
        n_tests++;
        if (first_e_cyc - c0 < 256 || first_e_cyc - c0 > 264) begin
            n_fail++;
            $display("FAIL power_wait first e at %0d cycles exp 256..264", first_e_cyc - c0);
        end
        exp = pad16("00+00=000");
        get_frame();
        n_tests++;
        if (frame_diff(exp) != -1 || !fr_rs_ok) begin
            n_fail++;
            $display("FAIL reset_frame got \"%s\" rs_ok=%0d exp \"%s\"", frame_str(), fr_rs_ok, exp);
        end
    endtask

    task automatic test_add_basic();
        string exp;
        repeat (40) @(negedge clk);
        press(0, 8'h3A);
        press(1, 8'hC5);
        exp = pad16("3A+00=03A");
        get_frame();
        n_tests++;
        if (frame_diff(exp) != -1 || !fr_rs_ok) begin
            n_fail++;
            $display("FAIL add_a_frame got \"%s\" rs_ok=%0d exp \"%s\"", frame_str(), fr_rs_ok, exp);
        end
        exp = pad16("3A+C5=0FF");
        get_frame();
        n_tests++;
        if (frame_diff(exp) != -1 || !fr_rs_ok) begin
            n_fail++;
            $display("FAIL add_frame got \"%s\" rs_ok=%0d exp \"%s\"", frame_str(), fr_rs_ok, exp);
        end
        n_tests++;
        if ({carry, ovf} !== 2'b00) begin
            n_fail++;
            $display("FAIL add_flags got carry=%b ovf=%b exp 0 0", carry, ovf);
        end
    endtask

    task automatic test_add_overflow();
        string exp;
        repeat (40) @(negedge clk);
        press(0, 8'h80);
        exp = pad16("80+C5=145");
        get_frame();
        n_tests++;
        if (frame_diff(exp) != -1 || !fr_rs_ok) begin
            n_fail++;
            $display("FAIL ovf_a_frame got \"%s\" rs_ok=%0d exp \"%s\"", frame_str(), fr_rs_ok, exp);
        end
        repeat (40) @(negedge clk);
        press(1, 8'h80);
        exp = pad16("80+80=100");
        get_frame();
        n_tests++;
        if (frame_diff(exp) != -1 || !fr_rs_ok) begin
            n_fail++;
            $display("FAIL ovf_frame got \"%s\" rs_ok=%0d exp \"%s\"", frame_str(), fr_rs_ok, exp);
        end
        n_tests++;
        if ({carry, ovf} !== 2'b11) begin
            n_fail++;
            $display("FAIL ovf_flags got carry=%b ovf=%b exp 1 1", carry, ovf);
        end
    endtask

    task automatic test_sub();
        int         idx[3]  = '{0, 1, 2};
        logic [7:0] val[3]  = '{8'h05, 8'h07, 8'h00};
        string      exps[3] = '{"05+80=085", "05+07=00C", "05-07=1FE"};
        string      exp;
        for (int i = 0; i < 3; i++) begin
            repeat (40) @(negedge clk);
            press(idx[i], val[i]);
            exp = pad16(exps[i]);
            get_frame();
            n_tests++;
            if (frame_diff(exp) != -1 || !fr_rs_ok) begin
                n_fail++;
                $display("FAIL sub_frame_%0d got \"%s\" rs_ok=%0d exp \"%s\"", i, frame_str(), fr_rs_ok, exp);
            end
        end
        n_tests++;
        if ({carry, ovf} !== 2'b10) begin
            n_fail++;
            $display("FAIL sub_flags got carry=%b ovf=%b exp 1 0", carry, ovf);
        end
    endtask

    task automatic test_hold_and_tear();
        string exp1 = pad16("11-07=00A");
        string exp2 = pad16("11-09=008");
        repeat (40) @(negedge clk);
        fork
            begin
                get_frame();
                n_tests++;
                if (frame_diff(exp1) != -1 || !fr_rs_ok) begin
                    n_fail++;
                    $display("FAIL hold_frame got \"%s\" rs_ok=%0d exp \"%s\"", frame_str(), fr_rs_ok, exp1);
                end
                get_frame();
                n_tests++;
                if (frame_diff(exp2) != -1 || !fr_rs_ok) begin
                    n_fail++;
                    $display("FAIL tear_next_frame got \"%s\" rs_ok=%0d exp \"%s\"", frame_str(), fr_rs_ok, exp2);
                end
            end
            begin
                @(negedge clk);
                sw     = 8'h11;
                btn[0] = 1'b1;
                repeat (10) @(negedge clk);
                sw = 8'h22;
                repeat (30) @(negedge clk);
                btn[0] = 1'b0;
                repeat (160) @(negedge clk);
                press(1, 8'h09);
            end
        join
        n_tests++;
        if ({carry, ovf} !== 2'b00) begin
            n_fail++;
            $display("FAIL hold_flags got carry=%b ovf=%b exp 0 0", carry, ovf);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [4:0] exp_init[12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                     5'h00, 5'h0C, 5'h00, 5'h01, 5'h00, 5'h06};
        logic [4:0] got;
        bit ok;
        int bad = -1;
        int t = 0;
        string exp;
        repeat (40) @(negedge clk);
        press(0, 8'h80);
        n_tests++;
        if ({carry, ovf} !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_reset_flags got carry=%b ovf=%b exp 0 1", carry, ovf);
        end
        repeat (200) @(negedge clk);
        while (!e && t < 40) begin
            @(negedge clk);
            t++;
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({e, rs, rw, d, c, b, a, carry, ovf, sf_e} !== 10'b0000000001) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got %b exp 0000000001", {e, rs, rw, d, c, b, a, carry, ovf, sf_e});
        end
        @(negedge clk);
        mon_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            get_nib(got, ok);
            if ((!ok || got !== exp_init[i]) && bad < 0) bad = i;
        end
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL reinit_sequence nibble %0d got %h exp %h", bad, got, exp_init[bad]);
        end
        exp = pad16("00+00=000");
        get_frame();
        n_tests++;
        if (frame_diff(exp) != -1 || !fr_rs_ok) begin
            n_fail++;
            $display("FAIL reinit_frame got \"%s\" rs_ok=%0d exp \"%s\"", frame_str(), fr_rs_ok, exp);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_overflow();
        test_sub();
        test_hold_and_tear();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
